// File: rtl/wca_packer_pkg.sv
// Shared types and constants for the IQ sample packer.
// The packer FSM states, the sat8 rounding constants, word widths and the
// debug struct that exposes the FSM state and FIFO fill level.
package wca_packer_pkg;

    localparam int SAMPLE_W = 32;
    localparam int WORD_W   = 16;
    localparam int HALF_W   = 8;
    // Wide enough for a fill count up to the largest supported depth (256).
    localparam int COUNT_W  = 9;

    localparam logic [16:0]       SAT8_ROUND = 17'h0_0080;
    localparam logic [HALF_W-1:0] SAT8_MAX   = 8'h7F;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WORD0 = 2'd1,
        S_WORD1 = 2'd2
    } packer_state_t;

    typedef struct packed {
        packer_state_t      state;
        logic               mode;
        logic [COUNT_W-1:0] fifo_count;
    } packer_dbg_t;

    // Round a 16-bit two's complement value to its top byte.
    // Only the positive side can overflow the signed byte range.
    function automatic logic [HALF_W-1:0] sat8(input logic [WORD_W-1:0] x);
        logic [16:0]       s;
        logic [HALF_W-1:0] r;
        s = {x[15], x} + SAT8_ROUND;
        if (!s[16] && s[15]) begin
            r = SAT8_MAX;
        end else begin
            r = s[15:8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wca_sync_fifo.sv
// Single-clock FIFO with synchronous clear.
// Push while full is ignored unless a pop happens in the same cycle; pop
// while empty is ignored. rdata always shows the head entry.
module wca_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage write; stale entries are invisible because count gates them.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and fill count; clear empties the FIFO like reset does.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wca_iq_sample_packer.sv
// IQ sample packer: buffers strobed 32-bit {Q,I} samples and emits them to
// the host as 16-bit words (I then Q) or one saturated 8+8-bit word.
// Optional build macro WCA_PACKER_OVF_COUNT_EN adds a saturating count of
// dropped samples on ovf_count; without it ovf_count reads zero.
//
// Output handshake: a word transfers on a rising edge where dvalid and dready
// are both high; while dvalid is high and dready low, dout and dfirst hold and
// dvalid stays high (only reset or aclr may withdraw it).
module wca_iq_sample_packer
    import wca_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                aclr,
    input  logic                mode8,
    input  logic                dstrobe_in,
    input  logic [SAMPLE_W-1:0] iq_in,
    output logic [WORD_W-1:0]   dout,
    output logic                dfirst,
    output logic                dvalid,
    input  logic                dready,
    output logic                overflow,
    output logic [7:0]          ovf_count,
    output packer_dbg_t         dbg
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    packer_state_t       state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic                mode_q;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [CW-1:0]       fifo_count;
    logic                dropped;

    // A strobe coincident with aclr is discarded: clear wins.
    assign fifo_push = dstrobe_in & enable & ~aclr;
    assign dropped   = fifo_push & fifo_full & ~fifo_pop;

    wca_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (aclr),
        .push  (fifo_push),
        .wdata (iq_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next state and pop decision; a pop always reloads the holding register.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_WORD0;
                end
            end
            S_WORD0: begin
                if (dready) begin
                    if (!mode_q) begin
                        state_d = S_WORD1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_WORD1: begin
                if (dready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = S_WORD0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // FSM state, holding register, latched packing mode and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset || aclr) begin
            state_q  <= S_LOAD;
            sample_q <= '0;
            mode_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                sample_q <= fifo_rdata;
                mode_q   <= mode8;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output word selection from the held sample and current state.
    always_comb begin
        dout   = '0;
        dfirst = 1'b0;
        case (state_q)
            S_WORD0: begin
                dfirst = 1'b1;
                if (mode_q) begin
                    dout = {sat8(sample_q[31:16]), sat8(sample_q[15:0])};
                end else begin
                    dout = sample_q[15:0];
                end
            end
            S_WORD1: dout = sample_q[31:16];
            default: dout = '0;
        endcase
    end

    assign dvalid = (state_q != S_LOAD);

`ifdef WCA_PACKER_OVF_COUNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating count of dropped samples.
    always_ff @(posedge clock) begin
        if (reset || aclr) begin
            drop_cnt_q <= '0;
        end else if (dropped && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign ovf_count = drop_cnt_q;
`else
    assign ovf_count = '0;
`endif

    assign dbg.state      = state_q;
    assign dbg.mode       = mode_q;
    assign dbg.fifo_count = COUNT_W'(fifo_count);

endmodule

// File: tb/tb_wca_iq_sample_packer.sv
// Bench for wca_iq_sample_packer: directed vector table, multi-cycle corner
// sequences and a randomized phase against a queue-based reference model.
module tb_wca_iq_sample_packer;
    import wca_packer_pkg::*;

    localparam int DEPTH = 16;

`ifdef WCA_PACKER_OVF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        aclr;
    logic        mode8;
    logic        dstrobe_in;
    logic [31:0] iq_in;
    logic [15:0] dout;
    logic        dfirst;
    logic        dvalid;
    logic        dready;
    logic        overflow;
    logic [7:0]  ovf_count;
    packer_dbg_t dbg;

    always #5 clock = ~clock;

    wca_iq_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .aclr       (aclr),
        .mode8      (mode8),
        .dstrobe_in (dstrobe_in),
        .iq_in      (iq_in),
        .dout       (dout),
        .dfirst     (dfirst),
        .dvalid     (dvalid),
        .dready     (dready),
        .overflow   (overflow),
        .ovf_count  (ovf_count),
        .dbg        (dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];      // {dfirst, dout}
    bit          sb_on = 1'b0;
    bit          prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    typedef struct {
        logic [31:0] iq;
        logic        m;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference saturating byte: round to nearest 256ths, clamp the top.
    function automatic logic [7:0] ref_sat8(input logic [15:0] x);
        int s;
        s = int'($signed(x)) + 128;
        if (s > 32767) return 8'd127;
        return 8'(s >>> 8);
    endfunction

    task automatic model_push(input logic [31:0] s, input logic m);
        if (m) begin
            exp_q.push_back({1'b1, ref_sat8(s[31:16]), ref_sat8(s[15:0])});
        end else begin
            exp_q.push_back({1'b1, s[15:0]});
            exp_q.push_back({1'b0, s[31:16]});
        end
    endtask

    task automatic sb_sample();
        if (prev_stall) begin
            check("hold_dvalid", 32'(dvalid), 32'd1);
            check("hold_word", 32'({dfirst, dout}), 32'(prev_word));
        end
        if (dvalid && dready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", {dfirst, dout});
            end else begin
                check("word", 32'({dfirst, dout}), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = dvalid & ~dready;
        prev_word  = {dfirst, dout};
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        if (sb_on) sb_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [31:0] s);
        dstrobe_in = 1'b1;
        iq_in      = s;
        tick();
        dstrobe_in = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        dready = 1'b1;
        while (exp_q.size() > 0 && n < max_cycles) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
        check("drained_dvalid", 32'(dvalid), 32'd0);
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          wps;
        int          n;

        vecs[0] = '{32'h1234_ABCD, 1'b0, 16'hABCD, 16'h1234};
        vecs[1] = '{32'h8000_7F90, 1'b1, 16'h807F, 16'h0000};
        vecs[2] = '{32'hFE7F_0180, 1'b1, 16'hFE02, 16'h0000};
        vecs[3] = '{32'h7FFF_8000, 1'b1, 16'h7F80, 16'h0000};
        vecs[4] = '{32'h007F_FF7F, 1'b1, 16'h00FF, 16'h0000};
        vecs[5] = '{32'h0080_FF80, 1'b1, 16'h0100, 16'h0000};
        vecs[6] = '{32'h7F7F_7F80, 1'b1, 16'h7F7F, 16'h0000};
        vecs[7] = '{32'hFFFF_0000, 1'b0, 16'h0000, 16'hFFFF};

        reset = 1'b1; enable = 1'b1; aclr = 1'b0; mode8 = 1'b0;
        dstrobe_in = 1'b0; iq_in = '0; dready = 1'b0;
        repeat (3) tick();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dfirst", 32'(dfirst), 32'd0);
        check("rst_dvalid", 32'(dvalid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_state", 32'(dbg.state), 32'(S_LOAD));
        reset = 1'b0;
        tick();

        // Single-sample latency and packing table.
        dready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode8 = vecs[i].m;
            strobe(vecs[i].iq);
            check("lat_c1_dvalid", 32'(dvalid), 32'd0);
            tick();
            check("vec_w0_dvalid", 32'(dvalid), 32'd1);
            check("vec_w0_dout", 32'(dout), 32'(vecs[i].w0));
            check("vec_w0_dfirst", 32'(dfirst), 32'd1);
            tick();
            if (!vecs[i].m) begin
                check("vec_w1_dout", 32'(dout), 32'(vecs[i].w1));
                check("vec_w1_dfirst", 32'(dfirst), 32'd0);
                check("vec_w1_dvalid", 32'(dvalid), 32'd1);
                tick();
            end
            check("vec_end_dvalid", 32'(dvalid), 32'd0);
        end

        // Back-to-back 8-bit samples appear on consecutive cycles.
        mode8 = 1'b1;
        strobe(32'h8000_7F90);
        strobe(32'hFE7F_0180);
        check("b2b_first", 32'({dvalid, dfirst, dout}), 32'({2'b11, 16'h807F}));
        tick();
        check("b2b_second", 32'({dvalid, dfirst, dout}), 32'({2'b11, 16'hFE02}));
        tick();
        check("b2b_end", 32'(dvalid), 32'd0);

        // Strobes ignored while enable is low.
        enable = 1'b0;
        strobe(32'hDEAD_BEEF);
        repeat (3) tick();
        check("disabled_dvalid", 32'(dvalid), 32'd0);
        check("disabled_count", 32'(dbg.fifo_count), 32'd0);
        enable = 1'b1;

        // Overflow: host stalled, 20 strobes, 17 retained.
        mode8 = 1'b0;
        dready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            if (k < 17) model_push(a, 1'b0);
            strobe(a);
            check("ovf_flag", 32'(overflow), 32'(k >= 17));
        end
        check("ovf_fifo_full", 32'(dbg.fifo_count), 32'(DEPTH));
        check("ovf_count", 32'(ovf_count), 32'(exp_cnt(3)));
        sb_on = 1'b1;
        prev_stall = 1'b0;
        drain(200);
        check("ovf_sticky", 32'(overflow), 32'd1);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        check("aclr_ovf", 32'(overflow), 32'd0);
        check("aclr_ovf_count", 32'(ovf_count), 32'd0);

        // Full FIFO with a pop coincident with a strobe: push accepted.
        mode8 = 1'b1;
        dready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            a = $urandom;
            model_push(a, 1'b1);
            strobe(a);
        end
        check("full_count", 32'(dbg.fifo_count), 32'(DEPTH));
        a = $urandom;
        model_push(a, 1'b1);
        dready = 1'b1;
        strobe(a);
        check("full_pop_push_ovf", 32'(overflow), 32'd0);
        check("full_pop_push_count", 32'(dbg.fifo_count), 32'(DEPTH));
        drain(200);
        check("full_end_ovf", 32'(overflow), 32'd0);

        // mode8 change during the second word does not tear the sample.
        mode8 = 1'b0;
        dready = 1'b0;
        a = $urandom;
        b = $urandom;
        model_push(a, 1'b0);
        model_push(b, 1'b1);
        strobe(a);
        strobe(b);
        check("toggle_state_w0", 32'(dbg.state), 32'(S_WORD0));
        dready = 1'b1;
        tick();
        check("toggle_state_w1", 32'(dbg.state), 32'(S_WORD1));
        mode8 = 1'b1;
        drain(20);

        // aclr with output valid, 5 buffered samples and a coincident strobe.
        sb_on = 1'b0;
        mode8 = 1'b0;
        dready = 1'b0;
        for (int k = 0; k < 6; k++) strobe($urandom);
        tick();
        check("pre_aclr_dvalid", 32'(dvalid), 32'd1);
        check("pre_aclr_count", 32'(dbg.fifo_count), 32'd5);
        aclr = 1'b1;
        strobe($urandom);
        aclr = 1'b0;
        check("aclr_dvalid", 32'(dvalid), 32'd0);
        check("aclr_fifo_empty", 32'(dbg.fifo_count), 32'd0);
        check("aclr_overflow", 32'(overflow), 32'd0);
        dready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("aclr_no_output", 32'(dvalid), 32'd0);
        end

        // Randomized phase against the reference queue, no overflow.
        sb_on = 1'b1;
        prev_stall = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            mode8 = 1'($urandom_range(0, 1));
            wps = mode8 ? 1 : 2;
            for (int c = 0; c < 300; c++) begin
                n = exp_q.size();
                dstrobe_in = ($urandom_range(0, 2) != 0) && (n < 15 * wps);
                enable = ($urandom_range(0, 7) != 0);
                dready = ($urandom_range(0, 3) != 0);
                iq_in = $urandom;
                if (dstrobe_in && enable) model_push(iq_in, mode8);
                tick();
            end
            dstrobe_in = 1'b0;
            enable = 1'b1;
            drain(400);
        end
        check("rand_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wca_iq_sample_packer.md
# wca_iq_sample_packer

Downstream stage of the DDC decimator: accepts strobed 32-bit IQ samples (I in [15:0], Q in [31:16], two's complement) and emits 16-bit words to the host transfer port through a valid/ready handshake. It buffers samples in a small synchronous FIFO to absorb host stalls, packs each sample as two 16-bit words or one 8+8-bit word, and flags dropped samples on overflow.

## Interface
- FIFO_DEPTH, 16, sample FIFO depth in 32-bit entries; power of two, 4..256
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; full reset
- enable  in  1  high = accept input strobes; low = ignore strobes, output keeps draining
- aclr  in  1  synchronous clear of FIFO, holding register, output and overflow state
- mode8  in  1  0 = 16-bit packing (2 words/sample), 1 = 8-bit packing (1 word/sample)
- dstrobe_in  in  1  one-cycle qualifier for iq_in
- iq_in  in  32  {Q[15:0], I[15:0]}
- dout  out  16  output word
- dfirst  out  1  high when dout is the first (or only) word of a sample
- dvalid  out  1  dout/dfirst valid
- dready  in  1  host accepts word when dvalid & dready at a rising edge
- overflow  out  1  sticky: at least one sample dropped since last reset/aclr
- ovf_count  out  8  dropped-sample count (only with WCA_PACKER_OVF_COUNT_EN)

## Operation
- Push: dstrobe_in & enable writes iq_in into FIFO. If FIFO full and no pop in the same cycle, the sample is dropped and overflow set. Full with simultaneous pop: push accepted.
- Packer FSM states: S_LOAD, S_WORD0, S_WORD1.
  - S_LOAD: if FIFO non-empty and (output register empty or being accepted this cycle), pop into holding register, latch mode8 into sample-mode bit, go S_WORD0. mode8 is sampled only here; changes mid-sample never tear a sample.
  - S_WORD0: present word0 (dfirst=1). 16-bit: dout = I. 8-bit: dout = {sat8(Q), sat8(I)}. On accept: 8-bit -> pop next sample if available (stay S_WORD0) else S_LOAD; 16-bit -> S_WORD1.
  - S_WORD1 (16-bit only): dout = Q, dfirst=0. On accept: pop next if available (S_WORD0) else S_LOAD.
- sat8(x): s = x + 0x0080 as 17-bit signed; if s > 0x7FFF result 0x7F, else s[15:8]. Negative inputs cannot saturate (-32768 -> 0x80).
- dout/dfirst stable while dvalid & ~dready; dvalid never drops without acceptance except on reset/aclr.
- aclr and reset: FIFO emptied, FSM to S_LOAD, dvalid=0, overflow=0, ovf_count=0; a strobe coincident with aclr is discarded (clear wins).

## Timing
- Reset values: dout=0, dfirst=0, dvalid=0, overflow=0, ovf_count=0.
- Latency: strobe in cycle 0 with FIFO empty and FSM in S_LOAD -> FIFO non-empty cycle 1, pop at edge ending cycle 1 -> dvalid=1 in cycle 2.
- Throughput with dready held high: 16-bit mode one sample per 2 cycles, 8-bit mode one sample per cycle, no bubbles between back-to-back samples.
- overflow asserts the cycle after the dropping strobe; ovf_count saturates at 255.
- FIFO count updates the cycle after push/pop; full = count==FIFO_DEPTH.

## Configuration
- WCA_PACKER_OVF_COUNT_EN defined: 8-bit saturating drop counter drives ovf_count, cleared by reset/aclr.
- Not defined: counter not built, ovf_count tied to 0; overflow flag unaffected.

## Structure
- Package wca_packer_pkg: FSM state enum (S_LOAD, S_WORD0, S_WORD1), SAT8_ROUND constant 0x0080, SAT8_MAX 0x7F, sample/word width constants.
- Sub-module wca_sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous clear); packer FSM and sat8 in top level.

## Test plan
- Single sample 0x1234_ABCD, mode8=0, dready=1 -> cycle 2 dout=0xABCD dfirst=1, cycle 3 dout=0x1234 dfirst=0, then dvalid=0.
- mode8=1, samples I=0x7F90/Q=0x8000 and I=0x0180/Q=0xFE7F -> dout=0x807F then 0xFE02 on consecutive cycles, dfirst=1 both.
- dready=0, 20 strobes with FIFO_DEPTH=16 -> first 16 + holding register retained, 3 dropped, overflow=1, ovf_count=3 (macro on); release dready -> exactly 17 samples emitted in order.
- Full FIFO, dready=1 pop coincident with strobe -> sample accepted, overflow stays 0.
- mode8 toggled while in S_WORD1 -> current sample finishes in 16-bit, next sample packed 8-bit.
- aclr asserted with dvalid=1 and FIFO holding 5 samples plus coincident strobe -> next cycle dvalid=0, FIFO empty, overflow=0, no further output.
